gray_counter_n: RTL and testbench

Parametrised N-bit Gray-code counter.
- Counts up or down, with count enable and synchronous parallel load.
- Provides Gray and binary views of the count, a terminal-count flag and a wrap pulse.
- Used as the pointer/sequence generator for clock-domain-safe pointers (async FIFO read/write pointers) and for low-toggle state sequencing.

---
 rtl/gray_counter_n_if.sv | 24 ++
 rtl/gray_counter_n.sv | 86 ++++++++
 tb/tb_gray_counter_n.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_n_if.sv
// Control/status bundle for gray_counter_n: the counter sits on the slave side
// and the block that drives and observes it sits on the master side.
interface gray_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  gray_out, bin_out, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output gray_out, bin_out, tc, wrap
    );
endinterface

// File: rtl/gray_counter_n.sv
// N-bit up/down Gray counter with parallel load, terminal count and wrap pulse.
// Define GRAY_COUNTER_SAT_EN to saturate at the end values instead of wrapping.
module gray_counter_n #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
    input  logic             clk,
    input  logic             rst,
    gray_counter_n_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_BIN = '1;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Step selection at the end value: saturating build holds, modulo build wraps.
    function automatic logic [WIDTH-1:0] end_step(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] stepped,
                                                  input logic             at_end_val);
`ifdef GRAY_COUNTER_SAT_EN
        return at_end_val ? cur : stepped;
`else
        if (at_end_val) begin
            return stepped;
        end
        return stepped | (cur & '0);
`endif
    endfunction

    logic [WIDTH-1:0] bin_p0;
    logic [WIDTH-1:0] gray_p0;
    logic             wrap_p0;

    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] bin_nxt;
    logic             at_end;
    logic             wrap_nxt;

    always_comb begin
        at_end   = bus.up_dn ? (bin_p0 == MAX_BIN) : (bin_p0 == '0);
        bin_step = bus.up_dn ? (bin_p0 + WIDTH'(1)) : (bin_p0 - WIDTH'(1));
        bin_nxt  = end_step(bin_p0, bin_step, at_end);
`ifdef GRAY_COUNTER_SAT_EN
        wrap_nxt = 1'b0;
`else
        wrap_nxt = at_end;
`endif
    end

    // Stage p0: binary state with its Gray image registered beside it
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_p0  <= gray2bin(RST_GRAY);
            gray_p0 <= RST_GRAY;
            wrap_p0 <= 1'b0;
        end else if (bus.load) begin
            bin_p0  <= gray2bin(bus.load_val);
            gray_p0 <= bus.load_val;
            wrap_p0 <= 1'b0;
        end else if (bus.en) begin
            bin_p0  <= bin_nxt;
            gray_p0 <= bin2gray(bin_nxt);
            wrap_p0 <= wrap_nxt;
        end else begin
            wrap_p0 <= 1'b0;
        end
    end

    assign bus.gray_out = gray_p0;
    assign bus.bin_out  = bin_p0;
    assign bus.wrap     = wrap_p0;
    // tc looks at the live enable/direction so it flags the step about to happen
    assign bus.tc       = bus.en & at_end;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n at WIDTH 3, 4 and 8, covering both the
// wrapping build and the GRAY_COUNTER_SAT_EN build.
module tb_gray_counter_n;

    logic clk = 1'b0;
    logic rst3 = 1'b1;
    logic rst4 = 1'b1;
    logic rst8 = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_counter_n_if #(.WIDTH(3)) b3 ();
    gray_counter_n_if #(.WIDTH(4)) b4 ();
    gray_counter_n_if #(.WIDTH(8)) b8 ();

    gray_counter_n #(.WIDTH(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));
    gray_counter_n #(.WIDTH(4)) u4 (.clk(clk), .rst(rst4), .bus(b4));
    gray_counter_n #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .bus(b8));

    // Gray sequence for 3 bits, binary index 0..7
    logic [2:0] g3_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic reset3();
        rst3 = 1'b1; b3.en = 1'b0; b3.load = 1'b0; b3.up_dn = 1'b1; b3.load_val = '0;
        tick();
        rst3 = 1'b0;
    endtask

    task automatic reset4();
        rst4 = 1'b1; b4.en = 1'b0; b4.load = 1'b0; b4.up_dn = 1'b1; b4.load_val = '0;
        tick();
        rst4 = 1'b0;
    endtask

    initial begin
        logic [7:0] m8;
        logic [7:0] prev_g;
        logic       exp_tc;
        logic       exp_wrap;
        logic       moved;

        b3.en = 0; b3.up_dn = 1; b3.load = 0; b3.load_val = '0;
        b4.en = 0; b4.up_dn = 1; b4.load = 0; b4.load_val = '0;
        b8.en = 0; b8.up_dn = 1; b8.load = 0; b8.load_val = '0;

        // Reset state
        reset3();
        #1;
        check("rst_gray3", 32'(b3.gray_out), 32'd0);
        check("rst_bin3",  32'(b3.bin_out),  32'd0);
        check("rst_wrap3", 32'(b3.wrap),     32'd0);
        check("rst_tc3",   32'(b3.tc),       32'd0);

`ifndef GRAY_COUNTER_SAT_EN
        // Full up cycle through the wrap
        b3.en = 1; b3.up_dn = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("up_gray3", 32'(b3.gray_out), 32'(g3_tab[k % 8]));
            check("up_bin3",  32'(b3.bin_out),  32'(k % 8));
            check("up_wrap3", 32'(b3.wrap),     32'(k == 8));
            check("up_tc3",   32'(b3.tc),       32'(k % 8 == 7));
        end

        // Down from reset wraps to max
        reset3();
        b3.en = 1; b3.up_dn = 0;
        #1;
        check("dn_tc0", 32'(b3.tc), 32'd1);
        tick();
        check("dn_gray7", 32'(b3.gray_out), 32'b100);
        check("dn_bin7",  32'(b3.bin_out),  32'd7);
        check("dn_wrap7", 32'(b3.wrap),     32'd1);
        check("dn_tc7",   32'(b3.tc),       32'd0);
        tick();
        check("dn_gray6", 32'(b3.gray_out), 32'b101);
        check("dn_bin6",  32'(b3.bin_out),  32'd6);
        check("dn_wrap6", 32'(b3.wrap),     32'd0);
`else
        // Saturating up: stops at 100 with no wrap
        b3.en = 1; b3.up_dn = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("sat_gray3", 32'(b3.gray_out), 32'(g3_tab[k > 7 ? 7 : k]));
            check("sat_bin3",  32'(b3.bin_out),  32'(k > 7 ? 7 : k));
            check("sat_wrap3", 32'(b3.wrap),     32'd0);
            check("sat_tc3",   32'(b3.tc),       32'(k >= 7));
        end
        b3.up_dn = 0;
        tick();
        check("sat_back_gray", 32'(b3.gray_out), 32'b101);
        check("sat_back_bin",  32'(b3.bin_out),  32'd6);

        // Saturating down at zero
        reset3();
        b3.en = 1; b3.up_dn = 0;
        tick();
        check("sat_dn_gray", 32'(b3.gray_out), 32'd0);
        check("sat_dn_wrap", 32'(b3.wrap),     32'd0);
        check("sat_dn_tc",   32'(b3.tc),       32'd1);
`endif

        // Direction change mid-sequence: up to 011 then down to 001
        reset3();
        b3.en = 1; b3.up_dn = 1;
        tick();
        tick();
        check("dir_up_gray", 32'(b3.gray_out), 32'b011);
        b3.up_dn = 0;
        tick();
        check("dir_dn_gray", 32'(b3.gray_out), 32'b001);
        check("dir_dn_bin",  32'(b3.bin_out),  32'd1);
        b3.en = 0;

        // Load wins over en
        reset4();
        b4.load = 1; b4.load_val = 4'b1101; b4.en = 1; b4.up_dn = 1;
        tick();
        check("ld_gray4", 32'(b4.gray_out), 32'b1101);
        check("ld_bin4",  32'(b4.bin_out),  32'd9);
        check("ld_wrap4", 32'(b4.wrap),     32'd0);
        b4.load = 0;
        tick();
        check("ld_step_gray", 32'(b4.gray_out), 32'b1111);
        check("ld_step_bin",  32'(b4.bin_out),  32'd10);
        // Reloading the current value is a no-op
        b4.load = 1; b4.load_val = 4'b1111;
        tick();
        check("ld_same_gray", 32'(b4.gray_out), 32'b1111);
        check("ld_same_wrap", 32'(b4.wrap),     32'd0);
        b4.load = 0; b4.en = 0;

        // Reset coincident with load and en, then hold
        reset4();
        b4.en = 1; b4.up_dn = 1;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_bin", 32'(b4.bin_out), 32'd5);
        rst4 = 1; b4.load = 1; b4.load_val = 4'b1101;
        tick();
        rst4 = 0; b4.load = 0; b4.en = 0;
        check("mid_rst_gray", 32'(b4.gray_out), 32'd0);
        check("mid_rst_bin",  32'(b4.bin_out),  32'd0);
        check("mid_rst_wrap", 32'(b4.wrap),     32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_gray4", 32'(b4.gray_out), 32'd0);
        end

`ifndef GRAY_COUNTER_SAT_EN
        // rst clears a pending wrap pulse
        b4.en = 1; b4.up_dn = 0;
        tick();
        check("w4_wrap", 32'(b4.wrap), 32'd1);
        rst4 = 1;
        tick();
        rst4 = 0; b4.en = 0;
        check("w4_rst_wrap", 32'(b4.wrap), 32'd0);
`endif

        // Random en/up_dn soak on WIDTH=8 against a small model
        rst8 = 1;
        tick();
        rst8 = 0;
        m8 = 8'd0;
        for (int c = 0; c < 600; c++) begin
            b8.en    = 1'($urandom);
            b8.up_dn = 1'($urandom);
            #1;
            exp_tc = b8.en & ((b8.up_dn & (m8 == 8'hFF)) | (~b8.up_dn & (m8 == 8'h00)));
            check("r8_tc", 32'(b8.tc), 32'(exp_tc));
            prev_g   = b8.gray_out;
            exp_wrap = 1'b0;
            if (b8.en) begin
`ifdef GRAY_COUNTER_SAT_EN
                if (!exp_tc) m8 = b8.up_dn ? m8 + 8'd1 : m8 - 8'd1;
`else
                exp_wrap = exp_tc;
                m8 = b8.up_dn ? m8 + 8'd1 : m8 - 8'd1;
`endif
            end
            moved = b8.en & ~(exp_tc & 1'b0);
`ifdef GRAY_COUNTER_SAT_EN
            moved = b8.en & ~exp_tc;
`endif
            tick();
            check("r8_bin",  32'(b8.bin_out), 32'(m8));
            check("r8_g2b",  32'(g2b8(b8.gray_out)), 32'(m8));
            check("r8_flip", $countones(b8.gray_out ^ prev_g), 32'(moved));
            check("r8_wrap", 32'(b8.wrap), 32'(exp_wrap));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
